// File: rtl/icache_tag_ctrl_if.sv
// Fetch, refill and tag-RAM signals between the icache tag controller (master) and its
// surroundings (slave). Signal suffixes are relative to the controller.
interface icache_tag_ctrl_if;
  logic        req_valid_i;
  logic [31:0] req_addr_i;
  logic        req_accept_o;
  logic        resp_valid_o;
  logic        flush_i;
  logic        refill_req_o;
  logic [31:0] refill_addr_o;
  logic        refill_ack_i;
  logic        refill_done_i;
  logic [7:0]  tag_addr_o;
  logic [19:0] tag_data_o;
  logic        tag_wr_o;
  logic [19:0] tag_data_i;
  logic        busy_o;

  modport master (
    input  req_valid_i, req_addr_i, flush_i, refill_ack_i, refill_done_i, tag_data_i,
    output req_accept_o, resp_valid_o, refill_req_o, refill_addr_o, tag_addr_o, tag_data_o,
    output tag_wr_o, busy_o
  );

  modport slave (
    output req_valid_i, req_addr_i, flush_i, refill_ack_i, refill_done_i, tag_data_i,
    input  req_accept_o, resp_valid_o, refill_req_o, refill_addr_o, tag_addr_o, tag_data_o,
    input  tag_wr_o, busy_o
  );
endinterface

// File: rtl/icache_tag_ctrl.sv
// Icache tag lookup / refill / invalidate controller in front of a read-first tag RAM.
// Optional hit/miss counters are enabled with the ICACHE_TAG_STATS_EN macro.
module icache_tag_ctrl #(
  parameter int unsigned FLUSH_LAST = 255
) (
  input logic               clk,
  input logic               rst,
  icache_tag_ctrl_if.master bus
`ifdef ICACHE_TAG_STATS_EN
  ,
  output logic [31:0]       hit_count_o,
  output logic [31:0]       miss_count_o
`endif
);

  localparam logic [7:0] LastIdx = FLUSH_LAST[7:0];

  typedef enum logic [2:0] {
    StFlush, StLookup, StMissReq, StMissWait, StWriteTag, StReplay
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic        outst_q, outst_d;
  logic        flush_pend_q, flush_pend_d;
  logic [31:0] addr_q, addr_d;
  logic        tag_match, cmp_hit, cmp_miss;

  assign tag_match = bus.tag_data_i[19] & (bus.tag_data_i[18:0] == addr_q[31:13]);
  assign cmp_hit   = pending_q & tag_match;
  assign cmp_miss  = pending_q & ~tag_match;

  assign bus.refill_addr_o = {addr_q[31:5], 5'b0};
  assign bus.busy_o        = (state_q != StLookup);

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    pending_d        = 1'b0;
    outst_d          = outst_q;
    flush_pend_d     = flush_pend_q | bus.flush_i;
    addr_d           = addr_q;
    bus.req_accept_o = 1'b0;
    bus.resp_valid_o = 1'b0;
    bus.refill_req_o = 1'b0;
    bus.tag_wr_o     = 1'b0;
    bus.tag_addr_o   = addr_q[12:5];
    bus.tag_data_o   = '0;
    unique case (state_q)
      StFlush: begin
        bus.tag_wr_o   = 1'b1;
        bus.tag_addr_o = cnt_q;
        cnt_d          = cnt_q + 8'd1;
        flush_pend_d   = 1'b0;
        if (bus.flush_i) begin
          cnt_d = '0;
        end else if (cnt_q == LastIdx) begin
          state_d = outst_q ? StReplay : StLookup;
        end
      end
      StLookup: begin
        bus.tag_addr_o = bus.req_addr_i[12:5];
        if (cmp_miss) begin
          state_d = StMissReq;
          outst_d = 1'b1;
        end else begin
          bus.resp_valid_o = cmp_hit;
          if (cmp_hit) outst_d = 1'b0;
          // A delivered hit goes out before the flush; no new accept in that cycle.
          if (flush_pend_q || bus.flush_i) begin
            state_d      = StFlush;
            cnt_d        = '0;
            flush_pend_d = 1'b0;
          end else begin
            bus.req_accept_o = 1'b1;
            if (bus.req_valid_i) begin
              addr_d    = bus.req_addr_i;
              pending_d = 1'b1;
            end
          end
        end
      end
      StMissReq: begin
        bus.refill_req_o = 1'b1;
        if (bus.refill_ack_i) state_d = StMissWait;
      end
      StMissWait: begin
        if (bus.refill_done_i) state_d = StWriteTag;
      end
      StWriteTag: begin
        bus.tag_wr_o   = 1'b1;
        bus.tag_data_o = {1'b1, addr_q[31:13]};
        if (flush_pend_q || bus.flush_i) begin
          state_d      = StFlush;
          cnt_d        = '0;
          flush_pend_d = 1'b0;
        end else begin
          state_d = StReplay;
        end
      end
      StReplay: begin
        // Re-read after the write cycle, since the read-first RAM returned stale data then.
        pending_d = 1'b1;
        state_d   = StLookup;
      end
      default: state_d = StFlush;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFlush;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      outst_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      outst_q      <= outst_d;
      flush_pend_q <= flush_pend_d;
      addr_q       <= addr_d;
    end
  end

`ifdef ICACHE_TAG_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == StLookup) begin
      if (cmp_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (cmp_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Directed bench for icache_tag_ctrl with a read-first tag RAM model and refill/tag-write
// scoreboards; build with ICACHE_TAG_STATS_EN defined to also check the counters.
module tb_icache_tag_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_tag_ctrl_if bus ();

  logic [31:0] hit_count, miss_count;

  icache_tag_ctrl #(.FLUSH_LAST(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ICACHE_TAG_STATS_EN
    ,
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count)
`endif
  );

`ifndef ICACHE_TAG_STATS_EN
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

  // 256 x 20 read-first single-port tag RAM
  logic [19:0] mem [256];
  logic [19:0] rd_q;
  always @(posedge clk) begin
    rd_q <= mem[bus.tag_addr_o];
    if (bus.tag_wr_o) mem[bus.tag_addr_o] <= bus.tag_data_o;
  end
  assign bus.tag_data_i = rd_q;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [31:0] refill_q [$];
  logic [27:0] tagwr_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sweep();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      chk("sweep", 32'({bus.busy_o, bus.tag_wr_o, bus.tag_addr_o, bus.tag_data_o}),
          32'({2'b11, 8'(i), 20'h0}));
    end
  endtask

  task automatic push_miss(input logic [31:0] addr);
    exp_misses++;
    refill_q.push_back({addr[31:5], 5'b0});
    tagwr_q.push_back({addr[12:5], 1'b1, addr[31:13]});
  endtask

  // Called at a negedge right after a miss compare; ends at the tag-write negedge (or after
  // the sweep when a flush is injected during the refill wait).
  task automatic service(input bit flush_in_wait);
    bit seen = 1'b0;
    logic [31:0] exp_ra;
    logic [27:0] exp_tw;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      seen = bus.refill_req_o;
    end
    chk("refill_req_seen", 32'(seen), 32'd1);
    exp_ra = (refill_q.size() != 0) ? refill_q.pop_front() : 32'hDEAD_BEEF;
    chk("refill_addr", bus.refill_addr_o, exp_ra);
    bus.refill_ack_i = 1'b1;
    @(posedge clk); #1 bus.refill_ack_i = 1'b0;
    @(negedge clk);
    chk("refill_req_drop", 32'(bus.refill_req_o), 32'd0);
    if (flush_in_wait) begin
      bus.flush_i = 1'b1;
      @(posedge clk); #1 bus.flush_i = 1'b0;
      @(negedge clk);
      chk("busy_in_wait", 32'(bus.busy_o), 32'd1);
    end
    bus.refill_done_i = 1'b1;
    @(posedge clk); #1 bus.refill_done_i = 1'b0;
    @(negedge clk);
    exp_tw = (tagwr_q.size() != 0) ? tagwr_q.pop_front() : 28'hFFF_FFFF;
    chk("tag_write", 32'({bus.tag_wr_o, bus.tag_addr_o, bus.tag_data_o}), 32'({1'b1, exp_tw}));
    if (flush_in_wait) sweep();
  endtask

  task automatic replay_check(input logic [31:0] addr, input bit exp_hit);
    @(negedge clk);
    chk("replay", 32'({bus.busy_o, bus.tag_wr_o, bus.tag_addr_o}), 32'({2'b10, addr[12:5]}));
    @(negedge clk);
    chk("replay_resp", 32'(bus.resp_valid_o), 32'(exp_hit));
  endtask

  // Starts and ends at a negedge with the controller in LOOKUP.
  task automatic lookup(input logic [31:0] addr, input bit exp_hit, input bit flush_in_wait);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    #1;
    chk("accept", 32'(bus.req_accept_o), 32'd1);
    chk("lookup_idx", 32'(bus.tag_addr_o), 32'(addr[12:5]));
    @(posedge clk); #1 bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("resp", 32'(bus.resp_valid_o), 32'(exp_hit));
    if (exp_hit) begin
      exp_hits++;
    end else begin
      push_miss(addr);
      service(flush_in_wait);
      if (flush_in_wait) begin
        replay_check(addr, 1'b0);
        push_miss(addr);
        service(1'b0);
      end
      replay_check(addr, 1'b1);
      exp_hits++;
    end
  endtask

  initial begin
    logic [31:0] b2b [3];
    bus.req_valid_i   = 1'b0;
    bus.req_addr_i    = '0;
    bus.flush_i       = 1'b0;
    bus.refill_ack_i  = 1'b0;
    bus.refill_done_i = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_outputs", 32'({bus.busy_o, bus.refill_req_o, bus.resp_valid_o, bus.req_accept_o,
                            bus.tag_wr_o}), 32'b10001);
    @(posedge clk); #1 rst = 1'b0;
    sweep();
    @(negedge clk);
    chk("post_sweep", 32'({bus.busy_o, bus.req_accept_o, bus.tag_wr_o}), 32'b010);

    // First fill of 0x1240
    lookup(32'h0000_1240, 1'b0, 1'b0);

    // Back-to-back hits in the same line
    b2b[0] = 32'h0000_1240; b2b[1] = 32'h0000_1244; b2b[2] = 32'h0000_1248;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = b2b[0];
    #1 chk("b2b_accept0", 32'(bus.req_accept_o), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      if (i < 3) bus.req_addr_i = b2b[i];
      else bus.req_valid_i = 1'b0;
      @(negedge clk);
      chk("b2b_resp", 32'(bus.resp_valid_o), 32'd1);
      if (i < 3) chk("b2b_accept", 32'(bus.req_accept_o), 32'd1);
      exp_hits++;
    end

    // Same index, different tag evicts, then the original misses again
    lookup(32'h0010_1240, 1'b0, 1'b0);
    lookup(32'h0000_1240, 1'b0, 1'b0);

    // Flush and request together: flush wins, request held across the sweep
    bus.flush_i     = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h0000_1240;
    #1 chk("flush_blocks_accept", 32'(bus.req_accept_o), 32'd0);
    @(posedge clk); #1 bus.flush_i = 1'b0;
    sweep();
    @(negedge clk);
    lookup(32'h0000_1240, 1'b0, 1'b0);

    // Flush during the refill wait: refill completes, sweep, replay misses and refills again
    lookup(32'h0000_2480, 1'b0, 1'b1);

`ifdef ICACHE_TAG_STATS_EN
    chk("hit_count", hit_count, 32'(exp_hits));
    chk("miss_count", miss_count, 32'(exp_misses));
`endif

    // Reset while requesting a refill
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h0000_3000;
    @(posedge clk); #1 bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_case_miss", 32'(bus.resp_valid_o), 32'd0);
    @(negedge clk);
    chk("rst_case_req", 32'({bus.refill_req_o, bus.refill_addr_o[30:0]}), 32'h8000_3000);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_refill", 32'({bus.refill_req_o, bus.busy_o, bus.tag_wr_o, bus.tag_addr_o,
                               bus.resp_valid_o, bus.req_accept_o}), 32'({3'b011, 8'h00, 2'b00}));
`ifdef ICACHE_TAG_STATS_EN
    chk("hit_count_rst", hit_count, 32'd0);
    chk("miss_count_rst", miss_count, 32'd0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    sweep();
    @(negedge clk);
    chk("after_rst_lookup", 32'({bus.busy_o, bus.req_accept_o, bus.refill_req_o}), 32'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
